// File: rtl/otp_pkg.sv
// otp_pkg: shared definitions for the OTP sequencer.
//   - OTP geometry (128 x 8 macro) and the program unlock key.
//   - Sequencer state encoding, also exported on the debug state port.
//   - is_setup_state(): states in which the pulse timer is loaded.
package otp_pkg;

    localparam int OTP_DEPTH = 128;
    localparam int OTP_AW    = 7;
    localparam int OTP_DW    = 8;

    localparam logic [OTP_DW-1:0] OTP_KEY = 8'hA5;

    typedef enum logic [3:0] {
        LOAD_SETUP  = 4'd0,
        LOAD_STROBE = 4'd1,
        LOAD_REC    = 4'd2,
        IDLE        = 4'd3,
        RD_SETUP    = 4'd4,
        RD_STROBE   = 4'd5,
        RD_REC      = 4'd6,
        PG_SETUP    = 4'd7,
        PG_PULSE    = 4'd8,
        PG_HOLD     = 4'd9,
        REJECT      = 4'd10
    } otp_state_e;

    // The timer is armed in every SETUP state so that it counts the
    // following STROBE/PULSE phase.
    function automatic logic is_setup_state(input otp_state_e s);
        return (s == LOAD_SETUP) || (s == RD_SETUP) || (s == PG_SETUP);
    endfunction

endpackage

// File: rtl/otp_pulse_timer.sv
// otp_pulse_timer: loadable down-counter used to time the rclk strobe
// and the pclk program pulse.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : load load_val into the counter this cycle
//   load_val    : phase length in cycles (>= 1)
//   tc          : high during the last cycle of the timed phase
//
// After a load with value N the counter shows N, N-1, ..., 1 in the
// next N cycles; tc marks the cycle where it shows 1. It then rests at 0.
module otp_pulse_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/otp_ctrl.sv
// otp_ctrl: single-clock sequencer in front of the 128x8 OTP macro.
// After reset it reads OTP bytes 0..LOAD_BYTES-1 and streams them to the
// trim-register bank (ld_*), then serves host read/program requests.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   host_req/wr/addr/wdata/key request (level), captured in IDLE only
//   host_ack/rdata/err         one-cycle completion, read data, key error
//   busy                       sequencer not in IDLE
//   load_done                  sticky, auto-load finished
//   ld_vld/ld_addr/ld_data     one pulse per auto-loaded byte
//   otp_cs_en/wrong/pclk/rclk  OTP control pins (registered)
//   otp_addr/otp_din           OTP address and program data (registered)
//   otp_dout                   OTP read data
//   dbg_state                  current sequencer state
//
// Host handshake: host_req is a level sampled only while IDLE (and only
// once load_done is set). The request is accepted on that edge and all
// request fields are captured then. host_ack pulses for exactly one cycle
// when the transaction completes; the sequencer is IDLE again the next
// cycle, so a requester that wants a single transaction drops host_req in
// the ack cycle, and one that keeps it high starts the next transaction.
//
// All pin outputs are registered from the next state, so each pin is
// glitch-free and changes exactly at the state boundary. otp_wrong is the
// inverse of otp_cs_en by construction.
module otp_ctrl
    import otp_pkg::*;
#(
    parameter int LOAD_BYTES = 128,
    parameter int RD_WAIT    = 4,
    parameter int PGM_PULSE  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [OTP_AW-1:0] host_addr,
    input  logic [OTP_DW-1:0] host_wdata,
    input  logic [OTP_DW-1:0] host_key,
    output logic              host_ack,
    output logic [OTP_DW-1:0] host_rdata,
    output logic              host_err,
    output logic              busy,
    output logic              load_done,
    output logic              ld_vld,
    output logic [OTP_AW-1:0] ld_addr,
    output logic [OTP_DW-1:0] ld_data,
    output logic              otp_cs_en,
    output logic              otp_wrong,
    output logic              otp_pclk,
    output logic              otp_rclk,
    output logic [OTP_AW-1:0] otp_addr,
    output logic [OTP_DW-1:0] otp_din,
    input  logic [OTP_DW-1:0] otp_dout,
    output otp_state_e        dbg_state
);

    localparam int TMAX = (RD_WAIT > PGM_PULSE) ? RD_WAIT : PGM_PULSE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [OTP_AW-1:0] LAST_PTR = OTP_AW'(LOAD_BYTES - 1);

    otp_state_e state_q, state_d;

    logic [OTP_AW-1:0] ld_ptr_q, ld_ptr_d;
    logic              load_done_q, load_done_d;
    logic [OTP_AW-1:0] ld_addr_q, ld_addr_d;
    logic [OTP_DW-1:0] ld_data_q, ld_data_d;
    logic              ld_vld_q, ld_vld_d;
    logic [OTP_DW-1:0] host_rdata_q, host_rdata_d;
    logic              host_ack_q, host_ack_d;
    logic              host_err_q, host_err_d;
    logic              busy_q, busy_d;
    logic              otp_cs_en_q, otp_cs_en_d;
    logic              otp_pclk_q, otp_pclk_d;
    logic              otp_rclk_q, otp_rclk_d;
    logic [OTP_AW-1:0] otp_addr_q, otp_addr_d;
    logic [OTP_DW-1:0] otp_din_q, otp_din_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_tc;

    assign tmr_load = is_setup_state(state_q);
    assign tmr_val  = (state_q == PG_SETUP) ? TW'(PGM_PULSE) : TW'(RD_WAIT);

    otp_pulse_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        ld_ptr_d     = ld_ptr_q;
        load_done_d  = load_done_q;
        ld_addr_d    = ld_addr_q;
        ld_data_d    = ld_data_q;
        host_rdata_d = host_rdata_q;
        otp_addr_d   = otp_addr_q;
        otp_din_d    = otp_din_q;

        case (state_q)
            LOAD_SETUP: begin
                state_d = LOAD_STROBE;
            end
            LOAD_STROBE: begin
                if (tmr_tc) begin
                    // dout has settled for RD_WAIT cycles of rclk high.
                    state_d   = LOAD_REC;
                    ld_data_d = otp_dout;
                    ld_addr_d = ld_ptr_q;
                end
            end
            LOAD_REC: begin
                if (ld_ptr_q == LAST_PTR) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                end else begin
                    state_d    = LOAD_SETUP;
                    ld_ptr_d   = ld_ptr_q + 1'b1;
                    otp_addr_d = ld_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                if (host_req && load_done_q) begin
                    if (!host_wr) begin
                        state_d    = RD_SETUP;
                        otp_addr_d = host_addr;
                    end else if (host_key == OTP_KEY) begin
                        state_d    = PG_SETUP;
                        otp_addr_d = host_addr;
                        otp_din_d  = host_wdata;
                    end else begin
                        // Bad key: answer without touching any OTP pin.
                        state_d = REJECT;
                    end
                end
            end
            RD_SETUP: begin
                state_d = RD_STROBE;
            end
            RD_STROBE: begin
                if (tmr_tc) begin
                    state_d      = RD_REC;
                    host_rdata_d = otp_dout;
                end
            end
            RD_REC: begin
                state_d = IDLE;
            end
            PG_SETUP: begin
                state_d = PG_PULSE;
            end
            PG_PULSE: begin
                if (tmr_tc) begin
                    state_d = PG_HOLD;
                end
            end
            PG_HOLD: begin
                state_d = IDLE;
            end
            REJECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin and handshake values for the state being entered.
    always_comb begin
        otp_cs_en_d = 1'b0;
        otp_pclk_d  = 1'b0;
        otp_rclk_d  = 1'b0;
        ld_vld_d    = 1'b0;
        host_ack_d  = 1'b0;
        host_err_d  = 1'b0;
        busy_d      = (state_d != IDLE);

        case (state_d)
            LOAD_SETUP, RD_SETUP, PG_SETUP: begin
                otp_cs_en_d = 1'b1;
            end
            LOAD_STROBE, RD_STROBE: begin
                otp_cs_en_d = 1'b1;
                otp_rclk_d  = 1'b1;
            end
            PG_PULSE: begin
                otp_cs_en_d = 1'b1;
                otp_pclk_d  = 1'b1;
            end
            PG_HOLD: begin
                // Chip select stays up one cycle past the pulse so that
                // addr/din are held across the pclk falling edge.
                otp_cs_en_d = 1'b1;
                host_ack_d  = 1'b1;
            end
            LOAD_REC: begin
                ld_vld_d = 1'b1;
            end
            RD_REC: begin
                host_ack_d = 1'b1;
            end
            REJECT: begin
                host_ack_d = 1'b1;
                host_err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LOAD_SETUP;
            ld_ptr_q     <= '0;
            load_done_q  <= 1'b0;
            ld_addr_q    <= '0;
            ld_data_q    <= '0;
            ld_vld_q     <= 1'b0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            host_err_q   <= 1'b0;
            busy_q       <= 1'b1;
            otp_cs_en_q  <= 1'b0;
            otp_pclk_q   <= 1'b0;
            otp_rclk_q   <= 1'b0;
            otp_addr_q   <= '0;
            otp_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            ld_ptr_q     <= ld_ptr_d;
            load_done_q  <= load_done_d;
            ld_addr_q    <= ld_addr_d;
            ld_data_q    <= ld_data_d;
            ld_vld_q     <= ld_vld_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            host_err_q   <= host_err_d;
            busy_q       <= busy_d;
            otp_cs_en_q  <= otp_cs_en_d;
            otp_pclk_q   <= otp_pclk_d;
            otp_rclk_q   <= otp_rclk_d;
            otp_addr_q   <= otp_addr_d;
            otp_din_q    <= otp_din_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign host_err   = host_err_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign ld_vld     = ld_vld_q;
    assign ld_addr    = ld_addr_q;
    assign ld_data    = ld_data_q;
    assign otp_cs_en  = otp_cs_en_q;
    assign otp_wrong  = ~otp_cs_en_q;
    assign otp_pclk   = otp_pclk_q;
    assign otp_rclk   = otp_rclk_q;
    assign otp_addr   = otp_addr_q;
    assign otp_din    = otp_din_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_otp_ctrl.sv
// tb_otp_ctrl: bench for otp_ctrl with a behavioural OTP macro, a
// reference memory image, and scoreboard queues for host acks and
// auto-load bytes, checked by a monitor on the falling clock edge.
module tb_otp_ctrl;
    import otp_pkg::*;

    localparam int LOAD_BYTES = 128;
    localparam int RD_WAIT    = 4;
    localparam int PGM_PULSE  = 8;
    localparam int LOAD_CYC   = LOAD_BYTES * (RD_WAIT + 2);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_req, host_wr;
    logic [6:0] host_addr;
    logic [7:0] host_wdata, host_key;
    logic       host_ack, host_err, busy, load_done, ld_vld;
    logic [7:0] host_rdata, ld_data;
    logic [6:0] ld_addr, otp_addr;
    logic       otp_cs_en, otp_wrong, otp_pclk, otp_rclk;
    logic [7:0] otp_din, otp_dout;
    otp_state_e dbg_state;

    otp_ctrl #(
        .LOAD_BYTES (LOAD_BYTES),
        .RD_WAIT    (RD_WAIT),
        .PGM_PULSE  (PGM_PULSE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_key   (host_key),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .host_err   (host_err),
        .busy       (busy),
        .load_done  (load_done),
        .ld_vld     (ld_vld),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .otp_cs_en  (otp_cs_en),
        .otp_wrong  (otp_wrong),
        .otp_pclk   (otp_pclk),
        .otp_rclk   (otp_rclk),
        .otp_addr   (otp_addr),
        .otp_din    (otp_din),
        .otp_dout   (otp_dout),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- OTP macro model ----------------
    logic [7:0] otp_mem [OTP_DEPTH];
    logic       pclk_seen = 1'b0;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < OTP_DEPTH; i++) otp_mem[i] <= 8'(i) ^ 8'h5A;
        end else if (otp_pclk && !pclk_seen && otp_cs_en) begin
            otp_mem[otp_addr] <= otp_din;
        end
        pclk_seen <= otp_pclk;
    end

    assign otp_dout = (otp_cs_en && otp_rclk) ? otp_mem[otp_addr] : 8'h00;

    // ---------------- reference model and scoreboard ----------------
    logic [7:0]  ref_mem [OTP_DEPTH];
    logic [7:0]  last_rdata;
    logic [40:0] exp_q[$];   // {ack cycle, err, rdata}
    logic [46:0] ld_q[$];    // {cycle, addr, data}
    int          done_cyc_exp;
    bit          abort_pending = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name,
                         input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int latency(input bit wr, input logic [7:0] key);
        if (!wr) return RD_WAIT + 2;
        if (key == OTP_KEY) return PGM_PULSE + 2;
        return 1;
    endfunction

    // Applies a transaction to the reference image and queues its answer.
    task automatic push_host(input bit wr, input logic [6:0] addr,
                             input logic [7:0] wdata, input logic [7:0] key,
                             input int ack_cyc);
        bit err = 1'b0;
        if (!wr) last_rdata = ref_mem[addr];
        else if (key == OTP_KEY) ref_mem[addr] = wdata;
        else err = 1'b1;
        exp_q.push_back({32'(ack_cyc), err, last_rdata});
    endtask

    task automatic expect_load(input int r);
        for (int i = 0; i < LOAD_BYTES; i++)
            ld_q.push_back({32'(r + 1 + i * (RD_WAIT + 2) + RD_WAIT), 7'(i), ref_mem[i]});
        done_cyc_exp = r + LOAD_CYC;
    endtask

    // ---------------- monitor ----------------
    logic [40:0] mon_e;
    logic [46:0] mon_l;
    bit cs_prev = 1'b0, pclk_prev = 1'b0, done_prev = 1'b0;
    int pclk_len = 0, cs_rises = 0, pclk_rises = 0, overlap_cnt = 0, wrong_bad = 0;

    always @(negedge clk) begin
        if (otp_pclk && otp_rclk) overlap_cnt++;
        if (otp_wrong === otp_cs_en) wrong_bad++;
        if (otp_cs_en && !cs_prev) cs_rises++;
        if (otp_pclk && !pclk_prev) pclk_rises++;
        if (otp_pclk) begin
            pclk_len++;
        end else begin
            if (pclk_prev) begin
                if (host_ack) check(pclk_len == PGM_PULSE, "pclk_width", pclk_len, PGM_PULSE);
                else check(abort_pending, "pclk_early_fall", pclk_len, PGM_PULSE);
            end
            pclk_len = 0;
        end
        cs_prev   = otp_cs_en;
        pclk_prev = otp_pclk;

        if (host_ack) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_ack", cyc, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check(cyc == int'(mon_e[40:9]), "ack_cycle", cyc, mon_e[40:9]);
                check({host_err, host_rdata} == mon_e[8:0], "ack_err_rdata",
                      {host_err, host_rdata}, mon_e[8:0]);
            end
        end

        if (ld_vld) begin
            if (ld_q.size() == 0) begin
                check(1'b0, "unexpected_ld_vld", cyc, 0);
            end else begin
                mon_l = ld_q.pop_front();
                check(cyc == int'(mon_l[46:15]), "ld_cycle", cyc, mon_l[46:15]);
                check({ld_addr, ld_data} == mon_l[14:0], "ld_addr_data",
                      {ld_addr, ld_data}, mon_l[14:0]);
            end
        end

        if (load_done && !done_prev) check(cyc == done_cyc_exp, "load_done_cycle", cyc, done_cyc_exp);
        done_prev = load_done;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check(1'b0, "idle_timeout", n, 0);
    endtask

    task automatic wait_ack(output int ack_cyc);
        int n = 0;
        ack_cyc = -1;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (host_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check(1'b0, "ack_timeout", n, 0);
    endtask

    task automatic txn(input bit wr, input logic [6:0] addr,
                       input logic [7:0] wdata, input logic [7:0] key);
        int ac;
        wait_idle();
        host_wr    = wr;
        host_addr  = addr;
        host_wdata = wdata;
        host_key   = key;
        host_req   = 1'b1;
        push_host(wr, addr, wdata, key, cyc + latency(wr, key));
        wait_ack(ac);
        host_req   = 1'b0;
        // Fields change after capture; the DUT must ignore this.
        host_addr  = ~addr;
        host_wdata = ~wdata;
    endtask

    task automatic b2b_reads(input int n);
        int ac, exp_c;
        logic [6:0] a;
        wait_idle();
        a         = 7'($urandom_range(0, 127));
        host_wr   = 1'b0;
        host_addr = a;
        host_req  = 1'b1;
        exp_c     = cyc + RD_WAIT + 2;
        push_host(1'b0, a, 8'h00, 8'h00, exp_c);
        for (int k = 0; k < n; k++) begin
            wait_ack(ac);
            if (k < n - 1) begin
                a         = 7'($urandom_range(0, 127));
                host_addr = a;
                exp_c     = exp_c + RD_WAIT + 3;
                push_host(1'b0, a, 8'h00, 8'h00, exp_c);
            end else begin
                host_req = 1'b0;
            end
        end
    endtask

    task automatic release_reset();
        last_rdata = 8'h00;
        exp_q.delete();
        ld_q.delete();
        expect_load(cyc);
        rst_n = 1'b1;
    endtask

    task automatic wait_load_done();
        int n = 0;
        while (!load_done && n < LOAD_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        check(load_done, "load_done_timeout", load_done, 1);
        check(ld_q.size() == 0, "ld_bytes_missing", ld_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ac, cs_before, pc_before, n;
        logic [7:0] k;

        rst_n      = 1'b0;
        host_req   = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_key   = '0;
        for (int i = 0; i < OTP_DEPTH; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        last_rdata = 8'h00;

        repeat (4) @(negedge clk);
        check({host_ack, host_err, busy, load_done, ld_vld, otp_cs_en, otp_wrong, otp_pclk, otp_rclk}
              == 9'b001000100, "reset_ctrl",
              {host_ack, host_err, busy, load_done, ld_vld, otp_cs_en, otp_wrong, otp_pclk, otp_rclk},
              9'b001000100);
        check({host_rdata, ld_addr, ld_data, otp_addr, otp_din} == '0, "reset_data",
              {host_rdata, ld_addr, ld_data, otp_addr, otp_din}, 0);

        // Release reset with a read already requested: it must wait for the load.
        release_reset();
        host_wr   = 1'b0;
        host_addr = 7'h05;
        host_req  = 1'b1;
        push_host(1'b0, 7'h05, 8'h00, 8'h00, done_cyc_exp + RD_WAIT + 2);
        wait_ack(ac);
        host_req = 1'b0;
        check(ld_q.size() == 0, "ld_bytes_missing", ld_q.size(), 0);

        // Directed program / read-back and bad-key rejection.
        txn(1'b1, 7'h12, 8'h3C, OTP_KEY);
        txn(1'b0, 7'h12, 8'h00, 8'h00);
        cs_before = cs_rises;
        pc_before = pclk_rises;
        txn(1'b1, 7'h20, 8'hFF, 8'h00);
        check({cs_rises, pclk_rises} == {cs_before, pc_before}, "reject_pin_activity",
              cs_rises - cs_before + pclk_rises - pc_before, 0);
        txn(1'b0, 7'h20, 8'h00, 8'h00);

        // Random mix of reads, programs and bad-key programs.
        for (int t = 0; t < 24; t++) begin
            k = OTP_KEY;
            if ($urandom_range(0, 3) == 0) begin
                k = 8'($urandom_range(0, 255));
                if (k == OTP_KEY) k = 8'h00;
            end
            txn(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                8'($urandom_range(0, 255)), k);
        end

        b2b_reads(5);

        // Reset in the middle of a program pulse.
        wait_idle();
        host_wr    = 1'b1;
        host_addr  = 7'h30;
        host_wdata = 8'h77;
        host_key   = OTP_KEY;
        host_req   = 1'b1;
        n = 0;
        while (!otp_pclk && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(otp_pclk, "pclk_start", otp_pclk, 1);
        repeat (2) @(negedge clk);
        // The fuse burn has begun, so the cell holds the new value.
        ref_mem[7'h30] = 8'h77;
        abort_pending  = 1'b1;
        rst_n          = 1'b0;
        host_req       = 1'b0;
        @(negedge clk);
        check({otp_pclk, otp_cs_en, busy, load_done, host_ack} == 5'b00100, "abort_reset_state",
              {otp_pclk, otp_cs_en, busy, load_done, host_ack}, 5'b00100);
        @(negedge clk);
        release_reset();
        @(negedge clk);
        abort_pending = 1'b0;
        wait_load_done();

        txn(1'b0, 7'h30, 8'h00, 8'h00);
        txn(1'b0, 7'h12, 8'h00, 8'h00);
        b2b_reads(3);

        repeat (5) @(negedge clk);
        check(overlap_cnt == 0, "pclk_rclk_overlap", overlap_cnt, 0);
        check(wrong_bad == 0, "wrong_not_inverse_cs", wrong_bad, 0);
        check(exp_q.size() == 0, "acks_missing", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otp_ctrl.md
# otp_ctrl

Single-clock sequencer in front of the 128×8 OTP macro. After reset it auto-loads the OTP contents and streams them to the trim-register bank. Afterwards it serves host read and program requests. It generates all OTP pin activity (cs_en, wrong, addr, din, pclk, rclk) and samples OTP dout after a programmable settle time.

## Interface
Parameters:
- LOAD_BYTES, 128: bytes auto-loaded after reset, addresses 0..LOAD_BYTES-1 (1..128).
- RD_WAIT, 4: cycles otp_rclk is held high before otp_dout is captured; must exceed the OTP 10 ns output delay (≥1).
- PGM_PULSE, 8: cycles otp_pclk is held high per program (≥1).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- host_req  in  1  transaction request, level; sampled only in IDLE.
- host_wr  in  1  1 = program, 0 = read.
- host_addr  in  7  OTP byte address.
- host_wdata  in  8  program data.
- host_key  in  8  program unlock key.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  8  read data, valid with host_ack, held until the next ack.
- host_err  out  1  valid with host_ack; 1 = program rejected (bad key).
- busy  out  1  FSM not in IDLE.
- load_done  out  1  sticky after the auto-load completes.
- ld_vld  out  1  one-cycle pulse per loaded byte.
- ld_addr  out  7  address of the loaded byte.
- ld_data  out  8  loaded byte.
- otp_cs_en, otp_wrong, otp_pclk, otp_rclk  out  1  OTP controls.
- otp_addr  out  7  OTP address.
- otp_din  out  8  OTP write data.
- otp_dout  in  8  OTP read data.

## Operation
- States: LOAD_SETUP, LOAD_STROBE, LOAD_REC, IDLE, RD_SETUP, RD_STROBE, RD_REC, PG_SETUP, PG_PULSE, PG_HOLD, REJECT.
- Reset values:
  - Outputs 0 except otp_wrong = 1 and busy = 1.
  - FSM enters LOAD_SETUP with load pointer 0.
- Read byte (load or host):
  - SETUP, 1 cycle: cs_en = 1, wrong = 0, addr driven, rclk = 0.
  - STROBE, RD_WAIT cycles: rclk = 1; otp_dout is registered on the last STROBE cycle.
  - REC, 1 cycle: rclk = 0, cs_en = 0, wrong = 1. In REC, ld_vld pulses (load) or host_ack pulses (host).
- Auto-load:
  - Pointer increments in each LOAD_REC.
  - After pointer LOAD_BYTES-1, go to IDLE; load_done rises on the cycle after the last ld_vld.
  - host_req is ignored until load_done = 1.
- Host program:
  - Checked in IDLE: host_key ≠ 8'hA5 → REJECT, 1 cycle: host_ack = 1, host_err = 1, no OTP pin changes.
  - Otherwise PG_SETUP, 1 cycle: cs_en = 1, wrong = 0, addr/din driven.
  - Then PG_PULSE, PGM_PULSE cycles: pclk = 1.
  - Then PG_HOLD, 1 cycle: pclk = 0, addr/din still held, host_ack = 1. Next cycle: cs_en = 0, wrong = 1.
- Host read is the read-byte sequence: RD_SETUP/RD_STROBE/RD_REC. host_err = 0.
- otp_pclk and otp_rclk are registered outputs and never high in the same cycle.
- otp_wrong = ~otp_cs_en at all times.
- host_addr, host_wdata, host_wr and host_key are captured in IDLE; later changes are ignored.

## Timing
- Host request sampled in IDLE at cycle T:
  - Read: ack at T+2+RD_WAIT.
  - Program: ack at T+2+PGM_PULSE.
  - Reject: ack at T+1.
- The FSM returns to IDLE the cycle after ack. If host_req is still high then, a new transaction starts, so the requester drops req in the ack cycle.
- Auto-load lasts LOAD_BYTES×(RD_WAIT+2) cycles: 768 with defaults. ld_vld spacing is RD_WAIT+2.
- Reset mid-operation:
  - All outputs take reset values at the next edge; pclk/rclk fall immediately.
  - No ack is issued for the aborted transaction.
  - load_done clears and the load restarts from address 0.

## Structure
- Shared package otp_pkg holds:
  - state encoding;
  - OTP_KEY = 8'hA5;
  - OTP_DEPTH = 128 and OTP_AW = 7;
  - OTP_DW = 8.
- One sub-module, otp_pulse_timer: loadable down-counter producing a terminal-count flag. It is reused for RD_WAIT and PGM_PULSE.

## Test plan
- Preload OTP model with mem[i] = i^8'h5A; release reset → 128 ld_vld pulses, ld_data = i^8'h5A, 6 cycles apart; load_done at cycle 769.
- After load, program addr 7'h12 = 8'h3C with key A5 → pclk high exactly 8 cycles; ack 10 cycles after req; a subsequent read of 7'h12 returns 8'h3C.
- Program with key 8'h00 → ack+err next cycle, no pclk/cs_en activity, mem unchanged.
- host_req asserted during auto-load → no ack until load_done; first ack then follows the normal latency.
- Assert rst_n = 0 during PG_PULSE → pclk low at the next edge, no ack; load restarts at address 0.
- Back-to-back reads holding req high → consecutive acks every RD_WAIT+3 cycles; pclk and rclk never both high.
